// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and sizing helpers.
// The retire bundle packs {has_rd, rd, rd_old, pc, data} with data in the LSBs.
package rob_pkg;

  localparam int RETIRE_W_MAX = 4;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int off_pc(input int data_w);
    return data_w;
  endfunction

  function automatic int off_rd_old(input int data_w, input int pc_w);
    return data_w + pc_w;
  endfunction

  function automatic int off_rd(input int data_w, input int pc_w, input int preg_w);
    return data_w + pc_w + preg_w;
  endfunction

  function automatic int off_has_rd(input int data_w, input int pc_w, input int preg_w);
    return data_w + pc_w + 2 * preg_w;
  endfunction

  function automatic int bundle_w(input int data_w, input int pc_w, input int preg_w);
    return data_w + pc_w + 2 * preg_w + 1;
  endfunction

  // Status half of an entry; the payload width depends on instance parameters.
  typedef struct packed {
    logic valid;
    logic done;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Finds the run of completed entries starting at head, capped at RETIRE_W.
module rob_retire_sel
  import rob_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int RETIRE_W = 2
) (
  input  logic [$clog2(DEPTH)-1:0]                head_idx,
  input  logic [DEPTH-1:0]                        valid,
  input  logic [DEPTH-1:0]                        done,
  output logic [$clog2(RETIRE_W+1)-1:0]           k,
  output logic [RETIRE_W-1:0][$clog2(DEPTH)-1:0]  slot_idx
);

  localparam int IW = idx_w(DEPTH);
  localparam int KW = $clog2(RETIRE_W + 1);

  logic run;

  always_comb begin
    k        = '0;
    run      = 1'b1;
    slot_idx = '0;
    for (int j = 0; j < RETIRE_W; j++) begin
      slot_idx[j] = head_idx + IW'(j);
      if (run && valid[slot_idx[j]] && done[slot_idx[j]]) k = k + KW'(1);
      else                                                  run = 1'b0;
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer: one dispatch per cycle, NUM_WB writeback buses,
// up to RETIRE_W in-order retirements per cycle, with whole-buffer flush.
module rob_multiport
  import rob_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int PREG_W   = 6,
  parameter int PC_W     = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_WB   = 3,
  parameter int RETIRE_W = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   disp_valid,
  output logic                                   disp_ready,
  input  logic                                   disp_has_rd,
  input  logic [PREG_W-1:0]                      disp_rd,
  input  logic [PREG_W-1:0]                      disp_rd_old,
  input  logic [PC_W-1:0]                        disp_pc,
  output logic [$clog2(DEPTH)-1:0]               disp_tag,
  input  logic [NUM_WB-1:0]                      wb_valid,
  input  logic [NUM_WB-1:0][$clog2(DEPTH)-1:0]   wb_tag,
  input  logic [NUM_WB-1:0][DATA_W-1:0]          wb_data,
  output logic [RETIRE_W-1:0]                    ret_valid,
  output logic [RETIRE_W-1:0]                    ret_has_rd,
  output logic [RETIRE_W-1:0][PREG_W-1:0]        ret_rd,
  output logic [RETIRE_W-1:0][PREG_W-1:0]        ret_rd_old,
  output logic [RETIRE_W-1:0][PC_W-1:0]          ret_pc,
  output logic [RETIRE_W-1:0][DATA_W-1:0]        ret_data,
  output logic [$clog2(DEPTH):0]                 count,
  output logic                                   full,
  output logic                                   empty
);

  localparam int IW   = idx_w(DEPTH);
  localparam int PW   = ptr_w(DEPTH);
  localparam int KW   = $clog2(RETIRE_W + 1);
  localparam int O_PC = off_pc(DATA_W);
  localparam int O_RO = off_rd_old(DATA_W, PC_W);
  localparam int O_RD = off_rd(DATA_W, PC_W, PREG_W);
  localparam int O_HR = off_has_rd(DATA_W, PC_W, PREG_W);
  localparam int BW   = bundle_w(DATA_W, PC_W, PREG_W);

  rob_entry_t [DEPTH-1:0]             ent;
  logic [DEPTH-1:0][BW-1:0]           payload;
  logic [PW-1:0]                      head, tail;
  logic [DEPTH-1:0]                   vld_v, done_v;
  logic [DEPTH-1:0]                   wb_hit;
  logic [DEPTH-1:0][DATA_W-1:0]       wb_sel;
  logic [KW-1:0]                      ret_k;
  logic [RETIRE_W-1:0][IW-1:0]        slot_idx;
  logic [IW-1:0]                      tail_idx;
  logic                               do_disp;

  assign count      = tail - head;
  assign full       = (count == PW'(DEPTH));
  assign empty      = (count == '0);
  assign disp_ready = !full;
  assign tail_idx   = tail[IW-1:0];
  assign disp_tag   = tail_idx;
  assign do_disp    = disp_valid && !full;

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      vld_v[e]  = ent[e].valid;
      done_v[e] = ent[e].done;
    end
  end

  // Scan buses high to low so the lowest-numbered bus wins a tag collision.
  always_comb begin
    wb_hit = '0;
    wb_sel = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int i = NUM_WB - 1; i >= 0; i--) begin
        if (wb_valid[i] && wb_tag[i] == IW'(e)) begin
          wb_hit[e] = 1'b1;
          wb_sel[e] = wb_data[i];
        end
      end
    end
  end

  rob_retire_sel #(.DEPTH(DEPTH), .RETIRE_W(RETIRE_W)) u_sel (
    .head_idx (head[IW-1:0]),
    .valid    (vld_v),
    .done     (done_v),
    .k        (ret_k),
    .slot_idx (slot_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent        <= '0;
      head       <= '0;
      tail       <= '0;
      ret_valid  <= '0;
      ret_has_rd <= '0;
      ret_rd     <= '0;
      ret_rd_old <= '0;
      ret_pc     <= '0;
      ret_data   <= '0;
    end else if (flush) begin
      ent       <= '0;
      head      <= '0;
      tail      <= '0;
      ret_valid <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++)
        if (wb_hit[e] && ent[e].valid) ent[e].done <= 1'b1;
      ret_valid <= '0;
      for (int j = 0; j < RETIRE_W; j++) begin
        if (j < int'(ret_k)) begin
          ret_valid[j]             <= 1'b1;
          ret_has_rd[j]            <= payload[slot_idx[j]][O_HR];
          ret_rd[j]                <= payload[slot_idx[j]][O_RD +: PREG_W];
          ret_rd_old[j]            <= payload[slot_idx[j]][O_RO +: PREG_W];
          ret_pc[j]                <= payload[slot_idx[j]][O_PC +: PC_W];
          ret_data[j]              <= payload[slot_idx[j]][DATA_W-1:0];
          ent[slot_idx[j]].valid   <= 1'b0;
        end
      end
      head <= head + PW'(ret_k);
      // A dispatching slot is never a retiring slot: that would need a full buffer.
      if (do_disp) begin
        ent[tail_idx] <= '{valid: 1'b1, done: 1'b0};
        tail          <= tail + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int e = 0; e < DEPTH; e++)
        if (wb_hit[e] && ent[e].valid) payload[e][DATA_W-1:0] <= wb_sel[e];
      if (do_disp)
        payload[tail_idx] <= {disp_has_rd, disp_rd, disp_rd_old, disp_pc, DATA_W'(0)};
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: queue-based program-order model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rob_multiport;

  localparam int DEPTH = 4, PREG_W = 6, PC_W = 12, DATA_W = 32, NUM_WB = 3, RETIRE_W = 2;
  localparam int IW = 2;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, disp_valid = 1'b0, disp_has_rd = 1'b0;
  logic [PREG_W-1:0] disp_rd = '0, disp_rd_old = '0;
  logic [PC_W-1:0]   disp_pc = '0;
  logic              disp_ready;
  logic [IW-1:0]     disp_tag;
  logic [NUM_WB-1:0] wb_valid = '0;
  logic [NUM_WB-1:0][IW-1:0]     wb_tag = '0;
  logic [NUM_WB-1:0][DATA_W-1:0] wb_data = '0;
  logic [RETIRE_W-1:0] ret_valid, ret_has_rd;
  logic [RETIRE_W-1:0][PREG_W-1:0] ret_rd, ret_rd_old;
  logic [RETIRE_W-1:0][PC_W-1:0]   ret_pc;
  logic [RETIRE_W-1:0][DATA_W-1:0] ret_data;
  logic [IW:0] count;
  logic full, empty;

  int n_chk = 0, n_pass = 0;

  rob_multiport #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PC_W(PC_W), .DATA_W(DATA_W),
                  .NUM_WB(NUM_WB), .RETIRE_W(RETIRE_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_has_rd(disp_has_rd), .disp_rd(disp_rd), .disp_rd_old(disp_rd_old), .disp_pc(disp_pc),
    .disp_tag(disp_tag), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .ret_valid(ret_valid), .ret_has_rd(ret_has_rd), .ret_rd(ret_rd), .ret_rd_old(ret_rd_old),
    .ret_pc(ret_pc), .ret_data(ret_data), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else             n_pass++;
  endtask

  // Program-order model: a queue of in-flight instructions.
  typedef struct {
    int       idx;
    bit       done;
    bit       has_rd;
    int       rd, rd_old, pc;
    bit [31:0] data;
  } m_ent_t;

  m_ent_t  q[$];
  m_ent_t  e_ret[RETIRE_W];
  m_ent_t  m_new;
  bit [RETIRE_W-1:0] e_rv = '0;
  int m_tail = 0, m_n, m_k;

  always @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      q.delete();
      m_tail = 0;
      e_rv   = '0;
    end else begin
      m_n  = q.size();
      m_k  = 0;
      e_rv = '0;
      while (m_k < RETIRE_W && m_k < q.size() && q[m_k].done) begin
        e_rv[m_k]   = 1'b1;
        e_ret[m_k]  = q[m_k];
        m_k++;
      end
      repeat (m_k) void'(q.pop_front());
      for (int i = NUM_WB - 1; i >= 0; i--)
        if (wb_valid[i])
          foreach (q[x])
            if (q[x].idx == int'(wb_tag[i])) begin
              q[x].done = 1'b1;
              q[x].data = wb_data[i];
            end
      if (disp_valid && m_n < DEPTH) begin
        m_new.idx    = m_tail % DEPTH;
        m_new.done   = 1'b0;
        m_new.has_rd = disp_has_rd;
        m_new.rd     = int'(disp_rd);
        m_new.rd_old = int'(disp_rd_old);
        m_new.pc     = int'(disp_pc);
        m_new.data   = '0;
        q.push_back(m_new);
        m_tail++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("disp_ready", disp_ready, q.size() < DEPTH);
      chk("disp_tag", disp_tag, m_tail % DEPTH);
      chk("ret_valid", ret_valid, e_rv);
      for (int j = 0; j < RETIRE_W; j++)
        if (e_rv[j]) begin
          chk($sformatf("ret_has_rd[%0d]", j), ret_has_rd[j], e_ret[j].has_rd);
          chk($sformatf("ret_rd[%0d]", j), ret_rd[j], e_ret[j].rd);
          chk($sformatf("ret_rd_old[%0d]", j), ret_rd_old[j], e_ret[j].rd_old);
          chk($sformatf("ret_pc[%0d]", j), ret_pc[j], e_ret[j].pc);
          chk($sformatf("ret_data[%0d]", j), ret_data[j], e_ret[j].data);
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    disp_valid = 1'b0;
    wb_valid   = '0;
    flush      = 1'b0;
  endtask

  task automatic idle(input int n);
    quiet();
    repeat (n) tick();
  endtask

  task automatic set_disp(input int pc, input int rd, input int ro);
    disp_valid  = 1'b1;
    disp_has_rd = 1'b1;
    disp_pc     = pc[PC_W-1:0];
    disp_rd     = rd[PREG_W-1:0];
    disp_rd_old = ro[PREG_W-1:0];
  endtask

  task automatic set_wb(input int bus, input int tag, input int data);
    wb_valid[bus] = 1'b1;
    wb_tag[bus]   = tag[IW-1:0];
    wb_data[bus]  = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit before summary");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_disp_tag", disp_tag, 0);
    chk("rst_ret_valid", ret_valid, 0);
    rst = 1'b1;
    tick();

    // single instruction end to end
    chk("t1_disp_tag", disp_tag, 0);
    set_disp('h004, 7, 3);
    tick(); quiet();
    chk("t1_count", count, 1);
    set_wb(0, 0, 'h55);
    tick(); quiet();
    chk("t1_no_ret_yet", ret_valid, 0);
    tick();
    chk("t1_ret_valid", ret_valid, 2'b01);
    chk("t1_ret_rd", ret_rd[0], 7);
    chk("t1_ret_rd_old", ret_rd_old[0], 3);
    chk("t1_ret_data", ret_data[0], 'h55);
    chk("t1_empty", empty, 1);
    tick();
    chk("t1_ret_clear", ret_valid, 0);

    // out-of-order completion
    flush = 1'b1; tick(); quiet();
    for (int n = 0; n < 3; n++) begin set_disp('h10 + n, n + 1, n + 20); tick(); end
    quiet();
    set_wb(0, 2, 'h22); tick(); quiet();
    set_wb(1, 1, 'h11); tick(); quiet();
    tick();
    chk("t2_blocked", ret_valid, 0);
    chk("t2_count", count, 3);
    set_wb(2, 0, 'h100); tick(); quiet();
    tick();
    chk("t2_ret2", ret_valid, 2'b11);
    chk("t2_pc0", ret_pc[0], 'h10);
    chk("t2_pc1", ret_pc[1], 'h11);
    tick();
    chk("t2_ret1", ret_valid, 2'b01);
    chk("t2_pc_last", ret_pc[0], 'h12);
    chk("t2_data_last", ret_data[0], 'h22);

    // full boundary
    flush = 1'b1; tick(); quiet();
    for (int n = 0; n < 5; n++) begin
      set_disp('h20 + n, n + 4, n);
      tick();
      if (n == 3) begin
        chk("t3_full", full, 1);
        chk("t3_not_ready", disp_ready, 0);
      end
    end
    chk("t3_count_hold", count, 4);
    set_disp('h2F, 1, 1);
    set_wb(0, 0, 'h30); tick(); wb_valid = '0;
    chk("t3_still_full", disp_ready, 0);
    tick(); quiet();
    chk("t3_count_after_ret", count, 3);
    chk("t3_ready_next", disp_ready, 1);
    set_wb(0, 1, 'h31); set_wb(1, 2, 'h32); set_wb(2, 3, 'h33);
    tick(); idle(3);
    chk("t3_drained", empty, 1);

    // wrap-around: each instruction completes the cycle after dispatch
    flush = 1'b1; tick(); quiet();
    for (int n = 0; n <= 12; n++) begin
      wb_valid = '0;
      if (n < 12) begin
        chk("t4_tag_seq", disp_tag, n % 4);
        set_disp('h100 + n, n % 8 + 1, n % 5);
      end else begin
        disp_valid = 1'b0;
      end
      if (n > 0) set_wb(n % 3, (n - 1) % 4, 'h1000 + n - 1);
      tick();
    end
    idle(3);
    chk("t4_empty", empty, 1);

    // writeback conflicts and unallocated tags
    flush = 1'b1; tick(); quiet();
    set_disp('h40, 1, 2); tick();
    set_disp('h41, 3, 4); tick(); quiet();
    set_wb(0, 1, 'hA); set_wb(2, 1, 'hB); set_wb(1, 3, 'hC);
    tick(); quiet();
    set_wb(0, 0, 'h9); tick(); quiet();
    tick();
    chk("t5_ret2", ret_valid, 2'b11);
    chk("t5_low_bus_wins", ret_data[1], 'hA);
    chk("t5_data0", ret_data[0], 'h9);
    set_disp('h42, 5, 6); set_wb(1, 2, 'hD);
    tick(); idle(3);
    chk("t5_unalloc_dropped", count, 1);
    chk("t5_no_ret", ret_valid, 0);
    set_wb(0, 2, 'hE); tick(); quiet();
    tick();
    chk("t5_ret_late", ret_valid, 2'b01);
    chk("t5_late_data", ret_data[0], 'hE);

    // flush beats dispatch, writeback and retire
    set_disp('h50, 7, 8); tick(); quiet();
    set_wb(0, 3, 'h5); tick(); quiet();
    flush = 1'b1; set_disp('h51, 9, 9); set_wb(1, 3, 'h7);
    tick(); quiet();
    chk("t6_flush_count", count, 0);
    chk("t6_flush_tag", disp_tag, 0);
    chk("t6_flush_no_ret", ret_valid, 0);
    tick();
    chk("t6_flush_no_ret2", ret_valid, 0);

    // asynchronous reset mid-cycle
    set_disp('h60, 1, 1); tick();
    set_disp('h61, 2, 2); set_wb(0, 0, 'h8); tick(); quiet();
    tick();
    chk("t7_pre_ret", ret_valid, 2'b01);
    chk("t7_pre_count", count, 1);
    #1 rst = 1'b0;
    #1;
    chk("t7_async_count", count, 0);
    chk("t7_async_empty", empty, 1);
    chk("t7_async_ready", disp_ready, 1);
    chk("t7_async_tag", disp_tag, 0);
    chk("t7_async_ret", ret_valid, 0);
    chk("t7_async_data", ret_data[0], 0);
    #1 rst = 1'b1;
    tick();
    set_disp('h70, 9, 8); tick(); quiet();
    set_wb(0, 0, 'h77); tick(); quiet();
    tick();
    chk("t7_post_ret", ret_valid, 2'b01);
    chk("t7_post_pc", ret_pc[0], 'h70);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rob_multiport.md
# rob_multiport

Parametrised reorder buffer for the out-of-order core; successor to the fixed single-size ROB. It allocates one entry per cycle at dispatch, accepts completions from `NUM_WB` writeback buses, and retires up to `RETIRE_W` contiguous completed entries per cycle in program order. It adds full/empty backpressure, occupancy reporting and a whole-buffer flush. It sits between the decode buffer/rename stage and the architectural register file and free pool.

## Interface
- `DEPTH`, 64: number of entries; must be a power of two, ≥4.
- `PREG_W`, 6: physical register tag width.
- `PC_W`, 12: PC width.
- `DATA_W`, 32: result width.
- `NUM_WB`, 3: number of writeback buses.
- `RETIRE_W`, 2: maximum retirements per cycle, 1..4.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of all entries.
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: equal to `!full`.
- `disp_has_rd` in 1: instruction writes a register.
- `disp_rd`, `disp_rd_old` in PREG_W each: new and previous physical tags.
- `disp_pc` in PC_W: instruction PC.
- `disp_tag` out log2(DEPTH): index that a dispatch in this cycle receives; equals `tail`.
- `wb_valid` in NUM_WB: per-bus completion strobe.
- `wb_tag` in NUM_WB×log2(DEPTH): packed ROB indices; bus i occupies slice i.
- `wb_data` in NUM_WB×DATA_W: packed results.
- `ret_valid` out RETIRE_W: per-slot retire strobe; slot 0 is the oldest.
- `ret_has_rd` out RETIRE_W.
- `ret_rd`, `ret_rd_old` out RETIRE_W×PREG_W.
- `ret_pc` out RETIRE_W×PC_W.
- `ret_data` out RETIRE_W×DATA_W.
- `count` out log2(DEPTH)+1: current occupancy.
- `full`, `empty` out 1 each.

## Operation
- Storage is a circular array. `head` and `tail` pointers are log2(DEPTH)+1 bits wide, and the MSB is the wrap bit.
  - `count = tail - head` (modulo).
  - `full` when `count == DEPTH`; `empty` when `count == 0`.
- Entry fields: `valid`, `done`, `has_rd`, `rd`, `rd_old`, `pc`, `data`.
- **Dispatch** happens when `disp_valid && disp_ready`:
  - entry[tail] is written with `valid=1`, `done=0` and the dispatch fields;
  - `tail` increments and wraps naturally.
  - A dispatch request while full is ignored, with no state change.
- **Writeback:** for each bus i with `wb_valid[i]` whose target entry has `valid=1`, the block sets `done=1` and stores `data`.
  - A writeback to an entry with `valid=0` is dropped.
  - If two buses carry the same tag in one cycle, the lowest-numbered bus supplies the data.
- **Retire selection:** k is the length of the contiguous run of entries from head with `valid && done`, capped at `RETIRE_W`.
  - Those k entries are cleared (`valid=0`) and `head` advances by k.
  - Their fields are registered onto `ret_*` slots 0..k-1 with `ret_valid` set for those slots.
  - The remaining slots have `ret_valid=0`; their other outputs are don't-care.
  - A non-done entry stops the run, so no entry behind it may retire.
- **Same-cycle events:**
  - Dispatch, writeback and retire may all occur in one cycle.
  - `disp_ready` reflects the pre-edge count only; slots freed by retirement are usable from the next cycle.
- **Flush** has priority over dispatch, writeback and retire in the same cycle:
  - all `valid` bits clear;
  - `head = tail = 0`;
  - `ret_valid` is 0 in the next cycle.
- **Reset** (async assert) sets:
  - all `valid`/`done` bits = 0, `head = tail = 0`;
  - `ret_*` = 0;
  - `count = 0`, `empty = 1`, `full = 0`, `disp_ready = 1`, `disp_tag = 0`.
  - Reset during operation discards all in-flight entries.

## Timing
- Dispatch at edge t: the entry can accept a writeback in cycle t+1.
- Writeback at edge t: `done` is visible at t; the entry can be selected in cycle t+1; `ret_valid` is asserted after edge t+1.
- Minimum dispatch-to-retire latency is therefore 3 edges: dispatch, writeback, retire select.
- `disp_ready`, `disp_tag`, `count`, `full` and `empty` are combinational from the pointers. They do not depend on same-cycle inputs.
- `ret_*` outputs are registered, with one-cycle latency after selection.
- Pointer wrap: the index is the low log2(DEPTH) bits, so retiring across index DEPTH-1→0 in one cycle is legal.

## Structure
- Shared package `rob_pkg`:
  - `rob_entry_t` struct;
  - index and pointer width functions based on `$clog2(DEPTH)`;
  - `RETIRE_W` maximum constant.
  - `rob_constants` retire-bundle field offsets move into this package.
- One combinational sub-module, `rob_retire_sel`:
  - inputs: head index, `valid`/`done` vectors;
  - outputs: count k and slot indices (head+j, wrapped).
- The top level holds the storage, pointers and registered retire outputs.

## Test plan
- **Reset, then single instruction:** reset; dispatch `pc=0x004`, `rd=7`, `rd_old=3` → `disp_tag=0`, `count=1`.
  - Writeback tag 0, `data=0x55` → two edges later `ret_valid=01`, `ret_rd=7`, `ret_rd_old=3`, `ret_data=0x55`, then `empty=1`.
- **Out-of-order completion:** dispatch tags 0,1,2; write back 2, then 1 → nothing retires. Write back 0 → next cycle retires 0,1 (RETIRE_W=2), the following cycle retires 2.
- **Full boundary:** DEPTH=4; dispatch 5 requests → `full=1` after 4 and `disp_ready=0`; the 5th is ignored and `count` stays 4.
  - Retire one → `disp_ready=1` only from the next cycle.
- **Wrap-around:** DEPTH=4; cycle 12 instructions with completion → `disp_tag` sequence 0,1,2,3,0,…, and the retire order matches dispatch order across the 3→0 boundary.
- **Writeback conflicts:** buses 0 and 2 target tag 1 with data 0xA and 0xB in the same cycle → `ret_data=0xA`.
  - Writeback to an unallocated tag → no `done` is set.
- **Flush and reset mid-operation:** flush together with a dispatch and a writeback → `count=0` and no retire follows.
  - Async `rst` low mid-cycle → outputs go to reset values immediately, without waiting for the clock edge.
